// File: rtl/dmi_jtag_host.sv
// dmi_jtag_host: JTAG initiator that turns DMI read/write requests into DTM IR/DR scans.
// Ports: clk_i/rst_i system clock and synchronous active-high reset;
//   req_valid_i/req_ready_o/req_addr_i/req_data_i/req_op_i DMI request handshake;
//   resp_valid_o/resp_ready_i/resp_data_o/resp_op_o DMI response handshake;
//   tck_o/tms_o/tdi_o/tdo_i/trst_no JTAG pins towards the DTM TAP.
// Build option: define DMI_HOST_IR_CACHE_EN to skip the IR scan once DMIACCESS is loaded.
module dmi_jtag_host #(
    parameter int                AbitsW     = 7,
    parameter int                ClkDiv     = 2,
    parameter int                IrLen      = 5,
    parameter logic [IrLen-1:0]  IrDmi      = 5'h11,
    parameter int                MaxRetries = 8,
    parameter int                IdleCycles = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic [AbitsW-1:0] req_addr_i,
    input  logic [31:0]       req_data_i,
    input  logic [1:0]        req_op_i,
    output logic              resp_valid_o,
    input  logic              resp_ready_i,
    output logic [31:0]       resp_data_o,
    output logic [1:0]        resp_op_o,
    output logic              tck_o,
    output logic              tms_o,
    output logic              tdi_o,
    input  logic              tdo_i,
    output logic              trst_no
);
    localparam int DrLen  = AbitsW + 34;
    localparam int IrLast = IrLen + 5;
    localparam int DrLast = DrLen + 4 + IdleCycles;
    localparam int CntW   = $clog2((DrLast > IrLast ? DrLast : IrLast) + 1);
    localparam int DivW   = $clog2(ClkDiv + 1);
    localparam int RetW   = $clog2(MaxRetries + 1);
`ifdef DMI_HOST_IR_CACHE_EN
    localparam bit CacheEn = 1'b1;
`else
    localparam bit CacheEn = 1'b0;
`endif

    typedef enum logic [2:0] {TAP_RST, IDLE, IR_SCAN, DR_REQ, DR_POLL, RESP} state_t;

    state_t            state;
    logic [CntW-1:0]   cnt;
    logic [DivW-1:0]   div;
    logic [RetW-1:0]   retries;
    logic [DrLen-1:0]  sr;
    logic [AbitsW-1:0] addr;
    logic [31:0]       data;
    logic [1:0]        op;
    logic              ir_valid;
    logic              run, last, shift_cur, shift_nxt, tms_nxt;

    // Each scan is a list of TCK steps; step 0 always leaves Run-Test/Idle with TMS=1.
    function automatic logic tms_at(state_t s, int c);
        return s == TAP_RST ? c < 6 :
               s == IR_SCAN ? (c < 2 || c == IrLen + 3 || c == IrLen + 4) :
                              (c == 0 || c == DrLen + 2 || c == DrLen + 3);
    endfunction

    function automatic logic shift_at(state_t s, int c);
        return s == IR_SCAN ? (c >= 4 && c < IrLen + 4) :
               (s == DR_REQ || s == DR_POLL) && c >= 3 && c < DrLen + 3;
    endfunction

    always_comb begin
        run       = state inside {TAP_RST, IR_SCAN, DR_REQ, DR_POLL};
        last      = int'(cnt) == (state == TAP_RST ? 6 : state == IR_SCAN ? IrLast : DrLast);
        shift_cur = shift_at(state, int'(cnt));
        shift_nxt = shift_at(state, int'(cnt) + 1);
        tms_nxt   = tms_at(state, int'(cnt) + 1);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state        <= TAP_RST;
            cnt          <= '0;
            div          <= '0;
            retries      <= '0;
            sr           <= '0;
            addr         <= '0;
            data         <= '0;
            op           <= '0;
            ir_valid     <= 1'b0;
            tck_o        <= 1'b0;
            tms_o        <= 1'b1;
            tdi_o        <= 1'b0;
            trst_no      <= 1'b0;
            req_ready_o  <= 1'b0;
            resp_valid_o <= 1'b0;
            resp_data_o  <= '0;
            resp_op_o    <= '0;
        end else if (!run) begin
            div   <= '0;
            tck_o <= 1'b0;
            if (state == IDLE && req_valid_i && req_ready_o) begin
                req_ready_o <= 1'b0;
                addr        <= req_addr_i;
                data        <= req_data_i;
                op          <= req_op_i;
                retries     <= '0;
                if (req_op_i == 2'd0 || req_op_i == 2'd3) begin
                    state        <= RESP;
                    resp_valid_o <= 1'b1;
                    resp_op_o    <= 2'd2;
                    resp_data_o  <= '0;
                end else if (CacheEn && ir_valid) begin
                    state <= DR_REQ;
                    tms_o <= 1'b1;
                    sr    <= {req_addr_i, req_data_i, req_op_i};
                end else begin
                    state <= IR_SCAN;
                    tms_o <= 1'b1;
                    sr    <= {{(DrLen - IrLen){1'b0}}, IrDmi};
                end
            end else if (state == RESP && resp_ready_i) begin
                state        <= IDLE;
                resp_valid_o <= 1'b0;
                req_ready_o  <= 1'b1;
            end
        end else if (int'(div) != ClkDiv - 1) begin
            div <= div + 1'b1;
        end else begin
            div   <= '0;
            tck_o <= ~tck_o;
            if (!tck_o) begin
                // Rising TCK: capture TDO; the shift register doubles as TX source and RX sink.
                if (shift_cur)
                    sr <= {tdo_i, sr[DrLen-1:1]};
            end else if (!last) begin
                cnt     <= cnt + 1'b1;
                tms_o   <= tms_nxt;
                tdi_o   <= shift_nxt & sr[0];
                trst_no <= 1'b1;
            end else begin
                cnt     <= '0;
                tdi_o   <= 1'b0;
                trst_no <= 1'b1;
                case (state)
                    TAP_RST: begin
                        state       <= IDLE;
                        req_ready_o <= 1'b1;
                    end
                    IR_SCAN: begin
                        state    <= DR_REQ;
                        ir_valid <= 1'b1;
                        tms_o    <= 1'b1;
                        sr       <= {addr, data, op};
                    end
                    DR_REQ: begin
                        state <= DR_POLL;
                        tms_o <= 1'b1;
                        sr    <= {addr, 32'h0, 2'b00};
                    end
                    DR_POLL: begin
                        if (sr[1:0] == 2'd3 && int'(retries) + 1 < MaxRetries) begin
                            retries <= retries + 1'b1;
                            tms_o   <= 1'b1;
                            sr      <= {addr, 32'h0, 2'b00};
                        end else begin
                            state        <= RESP;
                            resp_valid_o <= 1'b1;
                            resp_op_o    <= sr[1:0] == 2'd0 ? 2'd0 : sr[1:0] == 2'd3 ? 2'd3 : 2'd2;
                            resp_data_o  <= (sr[1:0] == 2'd0 && op == 2'd1) ? sr[33:2] : 32'h0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_dmi_jtag_host.sv
// tb_dmi_jtag_host: self-checking bench for dmi_jtag_host driving a behavioural DTM TAP model.
module tb_dmi_jtag_host;
`ifdef DMI_HOST_IR_CACHE_EN
    localparam bit Cache = 1'b1;
`else
    localparam bit Cache = 1'b0;
`endif
    localparam int MaxRetries = 8;

    logic        clk = 1'b0, rst_i = 1'b1;
    logic        req_valid = 1'b0, resp_ready = 1'b0, tdo = 1'b0;
    logic [6:0]  req_addr = '0;
    logic [31:0] req_data = '0;
    logic [1:0]  req_op = '0;
    logic        req_ready_o, resp_valid_o, tck_o, tms_o, tdi_o, trst_no;
    logic [31:0] resp_data_o;
    logic [1:0]  resp_op_o;

    always #5 clk = ~clk;

    dmi_jtag_host dut (
        .clk_i(clk), .rst_i(rst_i),
        .req_valid_i(req_valid), .req_ready_o(req_ready_o), .req_addr_i(req_addr),
        .req_data_i(req_data), .req_op_i(req_op),
        .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready),
        .resp_data_o(resp_data_o), .resp_op_o(resp_op_o),
        .tck_o(tck_o), .tms_o(tms_o), .tdi_o(tdi_o), .tdo_i(tdo), .trst_no(trst_no)
    );

    int n_checks = 0, n_pass = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Behavioural DTM: standard 16-state TAP with a DMIACCESS data register.
    typedef enum int {TLR, RTI, SELDR, CAPDR, SHDR, EX1DR, PDR, EX2DR, UPDR,
                      SELIR, CAPIR, SHIR, EX1IR, PIR, EX2IR, UPIR} tap_t;

    function automatic tap_t tap_next(tap_t s, logic m);
        case (s)
            TLR:   return m ? TLR   : RTI;
            RTI:   return m ? SELDR : RTI;
            SELDR: return m ? SELIR : CAPDR;
            CAPDR: return m ? EX1DR : SHDR;
            SHDR:  return m ? EX1DR : SHDR;
            EX1DR: return m ? UPDR  : PDR;
            PDR:   return m ? EX2DR : PDR;
            EX2DR: return m ? UPDR  : SHDR;
            UPDR:  return m ? SELDR : RTI;
            SELIR: return m ? TLR   : CAPIR;
            CAPIR: return m ? EX1IR : SHIR;
            SHIR:  return m ? EX1IR : SHIR;
            EX1IR: return m ? UPIR  : PIR;
            PIR:   return m ? EX2IR : PIR;
            EX2IR: return m ? UPIR  : SHIR;
            UPIR:  return m ? SELDR : RTI;
            default: return TLR;
        endcase
    endfunction

    tap_t        tap = TLR;
    logic [40:0] dr_sh = '0, last_req = '0;
    logic [4:0]  ir_sh = '0, ir = 5'h1;
    logic [31:0] rd_data = '0;
    int          sh_cnt = 0, ir_upd = 0, req_upd = 0, polls = 0, tck_rises = 0, busy_left = 0;
    bit          always_busy = 1'b0, fail = 1'b0;

    always @(posedge tck_o) begin
        tck_rises++;
        if (!trst_no) begin
            tap = TLR;
            ir  = 5'h1;
        end else begin
            case (tap)
                CAPDR: begin
                    dr_sh  = {7'h0, rd_data, (always_busy || busy_left > 0) ? 2'd3 : fail ? 2'd2 : 2'd0};
                    sh_cnt = 0;
                end
                SHDR: begin
                    dr_sh = {tdi_o, dr_sh[40:1]};
                    sh_cnt++;
                end
                UPDR: begin
                    if (dr_sh[1:0] != 2'd0) begin
                        last_req = dr_sh;
                        req_upd++;
                        chk("req_ir", 64'(ir), 64'(5'h11));
                    end else begin
                        polls++;
                        if (busy_left > 0) busy_left--;
                    end
                end
                CAPIR: ir_sh = 5'h1;
                SHIR:  ir_sh = {tdi_o, ir_sh[4:1]};
                UPIR: begin
                    ir = ir_sh;
                    ir_upd++;
                end
                default: ;
            endcase
            tap = tap_next(tap, tms_o);
            if (tap == TLR) ir = 5'h1;
        end
    end

    always @(negedge tck_o) tdo = tap == SHIR ? ir_sh[0] : dr_sh[0];

    // Per-cycle compare against the expected response of the outstanding transaction.
    logic [31:0] exp_data = '0, got_data = '0;
    logic [1:0]  exp_op = '0, got_op = '0;
    bit          outstanding = 1'b0, ir_loaded = 1'b0;
    logic        trst_prev = 1'b1;
    int          trst_lows = 0;

    always @(negedge clk) begin
        if (trst_prev && !trst_no) trst_lows++;
        trst_prev = trst_no;
        if (!rst_i) begin
            chk("ready_and_valid", 64'(req_ready_o & resp_valid_o), 64'(0));
            if (outstanding) chk("ready_while_busy", 64'(req_ready_o), 64'(0));
            if (resp_valid_o) begin
                chk("resp_data_cyc", 64'(resp_data_o), 64'(exp_data));
                chk("resp_op_cyc", 64'(resp_op_o), 64'(exp_op));
            end
        end
    end

    task automatic send_req(input logic [1:0] op, input logic [6:0] addr, input logic [31:0] wdata);
        int t;
        t = 0;
        @(negedge clk);
        while (!req_ready_o && t < 2000) begin
            @(negedge clk);
            t++;
        end
        chk("req_ready_wait", 64'(req_ready_o), 64'(1));
        if (!req_ready_o) return;
        req_valid = 1'b1;
        req_op    = op;
        req_addr  = addr;
        req_data  = wdata;
        @(posedge clk);
        #1 req_valid = 1'b0;
        outstanding = 1'b1;
    endtask

    task automatic wait_resp(input int hold);
        int t;
        t = 0;
        while (!resp_valid_o && t < 6000) begin
            @(negedge clk);
            t++;
        end
        chk("resp_wait", 64'(resp_valid_o), 64'(1));
        repeat (hold) @(negedge clk);
        got_data   = resp_data_o;
        got_op     = resp_op_o;
        resp_ready = 1'b1;
        @(posedge clk);
        #1 resp_ready = 1'b0;
        outstanding = 1'b0;
    endtask

    task automatic do_txn(input string name, input logic [1:0] op, input logic [6:0] addr,
                          input logic [31:0] wdata, input logic [31:0] rdata, input int busy,
                          input bit abusy, input bit fl, input int hold);
        bit legal;
        int ir0, rq0, tk0;
        legal = op == 2'd1 || op == 2'd2;
        ir0 = ir_upd;
        rq0 = req_upd;
        tk0 = tck_rises;
        rd_data = rdata;
        busy_left = busy;
        always_busy = abusy;
        fail = fl;
        polls = 0;
        exp_op   = !legal ? 2'd2 : abusy ? 2'd3 : fl ? 2'd2 : 2'd0;
        exp_data = (legal && !abusy && !fl && op == 2'd1) ? rdata : 32'h0;
        send_req(op, addr, wdata);
        wait_resp(hold);
        chk({name, "_op"}, 64'(got_op), 64'(exp_op));
        chk({name, "_data"}, 64'(got_data), 64'(exp_data));
        chk({name, "_polls"}, 64'(polls), 64'(!legal ? 0 : abusy ? MaxRetries : busy + 1));
        chk({name, "_ir_scans"}, 64'(ir_upd - ir0), 64'(legal && !(Cache && ir_loaded)));
        chk({name, "_req_scans"}, 64'(req_upd - rq0), 64'(legal));
        if (legal) begin
            chk({name, "_dr_word"}, 64'(last_req), 64'({addr, wdata, op}));
            chk({name, "_tap_rti"}, 64'(tap), 64'(RTI));
            ir_loaded = 1'b1;
        end else begin
            chk({name, "_no_tck"}, 64'(tck_rises - tk0), 64'(0));
        end
    endtask

    task automatic chk_reset_outputs(input string name);
        chk({name, "_tck"}, 64'(tck_o), 64'(0));
        chk({name, "_tms"}, 64'(tms_o), 64'(1));
        chk({name, "_tdi"}, 64'(tdi_o), 64'(0));
        chk({name, "_trst"}, 64'(trst_no), 64'(0));
        chk({name, "_ready"}, 64'(req_ready_o), 64'(0));
        chk({name, "_valid"}, 64'(resp_valid_o), 64'(0));
        chk({name, "_data"}, 64'(resp_data_o), 64'(0));
        chk({name, "_op"}, 64'(resp_op_o), 64'(0));
    endtask

    initial begin
        int t, vr, rq0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset_outputs("reset");
        rst_i = 1'b0;

        do_txn("write", 2'd2, 7'h10, 32'h0000_0001, 32'h0, 0, 1'b0, 1'b0, 0);
        chk("write_word_lit", 64'(last_req), 64'(41'h40_0000_0006));
        chk("write_trst_pulse", 64'(trst_lows), 64'(1));
        chk("write_trst_high", 64'(trst_no), 64'(1));

        do_txn("dmstatus", 2'd1, 7'h11, 32'h0, 32'h0040_0C82, 0, 1'b0, 1'b0, 10);
        chk("dmstatus_lit", 64'(got_data), 64'(32'h0040_0C82));
        chk("read_word_lit", 64'(last_req), 64'(41'h44_0000_0001));

        do_txn("busy3", 2'd1, 7'h04, 32'h0, 32'hDEAD_BEEF, 3, 1'b0, 1'b0, 0);
        chk("busy3_polls_lit", 64'(polls), 64'(4));
        chk("busy3_data_lit", 64'(got_data), 64'(32'hDEAD_BEEF));

        do_txn("timeout", 2'd1, 7'h04, 32'h0, 32'h5555_AAAA, 0, 1'b1, 1'b0, 0);
        chk("timeout_polls_lit", 64'(polls), 64'(8));
        chk("timeout_op_lit", 64'(got_op), 64'(3));

        do_txn("failed", 2'd2, 7'h17, 32'hCAFE_F00D, 32'h0, 0, 1'b0, 1'b1, 0);
        do_txn("illegal3", 2'd3, 7'h10, 32'h1, 32'h0, 0, 1'b0, 1'b0, 0);
        chk("illegal3_op_lit", 64'(got_op), 64'(2));
        do_txn("illegal0", 2'd0, 7'h10, 32'h1, 32'h0, 0, 1'b0, 1'b0, 0);

        // Abort a request while its DR scan is mid-shift.
        rd_data = '0;
        busy_left = 0;
        always_busy = 1'b0;
        fail = 1'b0;
        rq0 = req_upd;
        send_req(2'd2, 7'h05, 32'h1234_5678);
        t = 0;
        while (!(tap == SHDR && sh_cnt == 20 && req_upd == rq0) && t < 3000) begin
            @(negedge clk);
            t++;
        end
        chk("midscan_reached", 64'(t < 3000), 64'(1));
        rst_i = 1'b1;
        outstanding = 1'b0;
        ir_loaded = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_outputs("midscan_reset");
        rst_i = 1'b0;
        vr = 0;
        repeat (300) begin
            @(negedge clk);
            if (resp_valid_o) vr++;
        end
        chk("midscan_no_resp", 64'(vr), 64'(0));
        chk("midscan_no_update", 64'(req_upd - rq0), 64'(0));
        chk("midscan_trst_pulse", 64'(trst_lows), 64'(2));

        do_txn("after_reset", 2'd1, 7'h11, 32'h0, 32'h0000_00AA, 0, 1'b0, 1'b0, 0);
        do_txn("second", 2'd1, 7'h12, 32'h0, 32'h1357_9BDF, 1, 1'b0, 1'b0, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end
endmodule

// File: doc/dmi_jtag_host.md
Name: dmi_jtag_host

Overview:
- Host-side JTAG initiator that drives the DTM TAP (tck/tms/td_i/trst_ni) from a parallel DMI request/response interface.
- Used as the bench and FPGA bring-up driver for the debug subsystem, and as a bridge from an on-chip test controller.
- Converts each DMI read or write into IR/DR scans and returns the 32-bit result and status.
- Retries automatically while the DTM reports busy.

Parameters:
- AbitsW, 7, DMI address width; DR length is AbitsW+34.
- ClkDiv, 2, clk_i cycles per TCK half-period (>=1).
- IrLen, 5, TAP instruction register length.
- IrDmi, 5'h11, DMIACCESS instruction value.
- MaxRetries, 8, busy retries before an error response.
- IdleCycles, 4, Run-Test/Idle TCK cycles inserted after every DR update.

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  synchronous active-high reset.
- req_valid_i  in  1  DMI request valid.
- req_ready_o  out  1  host can accept a request.
- req_addr_i  in  AbitsW  DMI address.
- req_data_i  in  32  write data.
- req_op_i  in  2  1=read, 2=write; 0 and 3 are rejected.
- resp_valid_o  out  1  response valid.
- resp_ready_i  in  1  consumer accepts the response.
- resp_data_o  out  32  read data (0 for writes).
- resp_op_o  out  2  0=ok, 2=failed, 3=busy timeout.
- tck_o  out  1  JTAG clock to the DTM.
- tms_o  out  1  JTAG mode select.
- tdi_o  out  1  JTAG data to the DTM (drives DTM td_i).
- tdo_i  in  1  JTAG data from the DTM (DTM td_o).
- trst_no  out  1  TAP reset, active low.

Behaviour:
- **Reset (rst_i=1):**
  - Outputs: tck_o=0, tms_o=1, tdi_o=0, trst_no=0, req_ready_o=0, resp_valid_o=0, resp_data_o=0, resp_op_o=0.
  - IR-valid flag cleared; FSM enters TAP_RST.
  - Reset asserted mid-scan aborts the scan immediately with no response; the DTM is re-synchronised by TAP_RST.
- **TCK generation:**
  - A divider toggles tck_o every ClkDiv clk_i cycles, only while a scan or sequence is active; otherwise tck_o is held at 0.
  - tms_o and tdi_o change only on the clk_i edge that drives tck_o 1->0.
  - tdo_i is sampled on the clk_i edge that drives tck_o 0->1.
- **FSM states:**
  - TAP_RST: trst_no=0 for 1 TCK, then trst_no=1; 5 TCKs with TMS=1, then 1 TCK with TMS=0 (Run-Test/Idle); then IDLE.
  - IDLE: req_ready_o=1. A handshake (req_valid_i & req_ready_o) latches addr/data/op and clears the retry count.
    - If op is 0 or 3: go straight to RESP with resp_op_o=2 and no JTAG activity.
    - Otherwise go to IR_SCAN.
  - IR_SCAN:
    - TMS sequence 1,1,0,0, then IrLen shift bits of IrDmi LSB first.
    - TMS=1 on the last shift bit, then TMS 1,0; ends in Run-Test/Idle. Then DR_REQ.
  - DR_REQ:
    - TMS 1,0,0, then shift AbitsW+34 bits LSB first of {addr,data,op}; TMS=1 on the last bit, then 1,0.
    - Then IdleCycles TCKs with TMS=0. Then DR_POLL.
  - DR_POLL:
    - Identical scan with op=0 (nop); captured TDO bits form the response.
    - Captured op 0: data = bits[33:2]; go to RESP.
    - Captured op 2: go to RESP with resp_op_o=2.
    - Captured op 3 (busy): retry count +1; repeat DR_POLL after IdleCycles. When the count reaches MaxRetries, go to RESP with resp_op_o=3.
  - RESP: resp_valid_o=1 and held stable until resp_ready_i; then IDLE.
- **Timing and ordering:**
  - Captured bit order: the first sampled bit is DR bit 0.
  - Minimum latency for a write with IR cached, ClkDiv=2, AbitsW=7, IdleCycles=4: 2*(3+41+2+4) TCK = 400 clk_i cycles plus 2.
  - req_ready_o=0 in every state except IDLE; only one transaction is outstanding.
  - resp_valid_o and req_ready_o are never asserted in the same cycle.

Optional Feature:
- Macro: DMI_HOST_IR_CACHE_EN.
- Defined:
  - An IR-valid flag is set after the first IR_SCAN and cleared by reset.
  - While the flag is set, IDLE goes straight to DR_REQ and skips IR_SCAN.
- Undefined: every transaction performs IR_SCAN.

Test Plan:
- **Reset then write:** reset 3 cycles, write addr 0x10 data 0x0000_0001, DTM responds ok -> trst_no pulses low; DR shifted = {7'h10, 32'h1, 2'b10}; resp_op_o=0, resp_data_o=0.
- **Read dmstatus:** read addr 0x11, DM returns 0x0040_0C82 -> resp_valid_o with resp_data_o=0x0040_0C82, resp_op_o=0.
- **Busy retries:** DTM model returns busy for 3 polls, then ok data 0xDEAD_BEEF -> exactly 4 DR_POLL scans; resp_data_o=0xDEAD_BEEF.
- **Busy timeout:** model always busy, MaxRetries=8 -> 8 poll scans; resp_op_o=3.
- **Back-pressure and illegal op:**
  - resp_ready_i held 0 for 10 cycles -> resp_valid_o and data stay stable; req_ready_o stays 0.
  - Then op=3 -> immediate resp_op_o=2 with no TCK edges.
- **Reset mid-scan and IR cache:** rst_i during DR_REQ bit 20 -> no response; next request performs TAP_RST then IR_SCAN. With DMI_HOST_IR_CACHE_EN defined, a second request shows no IR scan.
